dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 189 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Request/response bundle between a CPU load/store port and the
//   data-memory responder.
//   master : CPU side (drives req_valid/we/funct3/addr/wdata)
//   slave  : responder side (drives req_ready, rsp_valid/rdata/err)
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Word-organised data memory answering RV32I-style byte/half/word
//   loads and stores with a programmable number of wait states.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-low reset
//     bus  - dmem_responder_if.slave request/response bundle
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | ready for a request (req_ready=1)
//   WAIT  | request latched, counting down wait states
//   RESP  | one-cycle response strobe (rsp_valid=1)
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int         IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

  logic [1:0]  state;
  logic [3:0]  cnt;

  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [11:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;

  // With no wait states the access happens on the accepting edge, so the
  // live bus fields are used in IDLE and the latched copy afterwards.
  logic        op_we;
  logic [2:0]  op_funct3;
  logic [11:0] op_addr;
  logic [31:0] op_wdata;

  logic          op_illegal;
  logic          op_misalign;
  logic          op_err;
  logic [IW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   load_val;
  logic [3:0]    byte_en;
  logic [31:0]   wr_lanes;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign accept = (state == S_IDLE) && bus.req_valid;
  assign commit = (accept && NO_WAIT) || ((state == S_WAIT) && (cnt == 4'd0));

  assign op_we     = (state == S_IDLE) ? bus.req_we     : lat_we;
  assign op_funct3 = (state == S_IDLE) ? bus.req_funct3 : lat_funct3;
  assign op_addr   = (state == S_IDLE) ? bus.req_addr   : lat_addr;
  assign op_wdata  = (state == S_IDLE) ? bus.req_wdata  : lat_wdata;

  assign word_idx = IW'(32'(op_addr[11:2]) % 32'(DEPTH_WORDS));
  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {op_addr[1:0], 3'b000};

  always_comb begin
    op_illegal  = 1'b0;
    op_misalign = 1'b0;
    load_val    = 32'd0;
    byte_en     = 4'b0000;
    wr_lanes    = op_wdata;
    if (op_we) begin
      op_illegal = (op_funct3 > 3'b010);
    end else begin
      op_illegal = (op_funct3 == 3'b011) || (op_funct3 == 3'b110) ||
                   (op_funct3 == 3'b111);
    end
    // funct3[1:0] encodes size for every legal code
    case (op_funct3[1:0])
      2'b01:   op_misalign = op_addr[0];
      2'b10:   op_misalign = (op_addr[1:0] != 2'b00);
      default: op_misalign = 1'b0;
    endcase
    case (op_funct3)
      3'b000: load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001: load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010: load_val = rd_word;
      3'b100: load_val = {24'd0, rd_shift[7:0]};
      3'b101: load_val = {16'd0, rd_shift[15:0]};
      default: load_val = 32'd0;
    endcase
    case (op_funct3[1:0])
      2'b00: begin
        byte_en  = 4'b0001 << op_addr[1:0];
        wr_lanes = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        byte_en  = op_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{op_wdata[15:0]}};
      end
      2'b10: begin
        byte_en  = 4'b1111;
        wr_lanes = op_wdata;
      end
      default: begin
        byte_en  = 4'b0000;
        wr_lanes = op_wdata;
      end
    endcase
  end

  assign op_err = op_illegal || op_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (NO_WAIT) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we     <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_addr   <= 12'd0;
      lat_wdata  <= 32'd0;
    end else if (accept) begin
      lat_we     <= bus.req_we;
      lat_funct3 <= bus.req_funct3;
      lat_addr   <= bus.req_addr;
      lat_wdata  <= bus.req_wdata;
    end
  end

  // Response data only moves on the commit edge and holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else if (commit) begin
      rsp_err_q   <= op_err;
      rsp_rdata_q <= (op_err || op_we) ? 32'd0 : load_val;
    end
  end

  // Storage is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (commit && op_we && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vec_t tbl[$];
  vec_t strm[$];

  dmem_responder_if bus1 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(virtual dmem_responder_if v, input vec_t t);
    v.req_we     = t.we;
    v.req_funct3 = t.f3;
    v.req_addr   = t.addr;
    v.req_wdata  = t.wdata;
  endtask

  task automatic scramble(virtual dmem_responder_if v);
    v.req_we     = 1'($urandom);
    v.req_funct3 = 3'($urandom);
    v.req_addr   = 12'($urandom);
    v.req_wdata  = $urandom;
  endtask

  // One isolated request: checks latency, data, error, strobe width and hold.
  task automatic do_req(virtual dmem_responder_if v, input int w, input vec_t t, input string nm);
    int n;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    n = 0;
    while (!v.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_int({nm, " ready"}, int'(v.req_ready), 1);
    v.req_valid = 1'b1;
    drive(v, t);
    @(posedge clk);
    #1;
    v.req_valid = 1'b0;
    scramble(v);
    n = 1;
    while (!v.rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_int({nm, " latency"}, n, w + 1);
    rd = v.rsp_rdata;
    er = v.rsp_err;
    check32({nm, " rdata"}, rd, t.exp_rdata);
    check32({nm, " err"}, {31'd0, er}, {31'd0, t.exp_err});
    @(posedge clk);
    #1;
    check_int({nm, " strobe width"}, int'(v.rsp_valid), 0);
    @(posedge clk);
    #1;
    check32({nm, " rdata hold"}, v.rsp_rdata, t.exp_rdata);
    check32({nm, " err hold"}, {31'd0, v.rsp_err}, {31'd0, t.exp_err});
  endtask

  // Continuous req_valid: one acceptance per w+2 cycles, responses in order.
  task automatic stream(virtual dmem_responder_if v, input int w, input string tag);
    int sent, got, cyc, last_acc;
    int acc_cyc[$];
    logic rdy;
    sent = 0; got = 0; cyc = 0; last_acc = -1;
    while (got < strm.size() && cyc < 200) begin
      @(negedge clk);
      rdy = v.req_ready;
      if (sent < strm.size()) begin
        v.req_valid = 1'b1;
        drive(v, strm[sent]);
      end else begin
        v.req_valid = 1'b0;
      end
      @(posedge clk);
      cyc++;
      if (rdy && sent < strm.size()) begin
        if (last_acc >= 0) check_int({tag, " spacing"}, cyc - last_acc, w + 2);
        last_acc = cyc;
        acc_cyc.push_back(cyc);
        sent++;
      end
      #1;
      if (v.rsp_valid) begin
        if (got < sent) begin
          check_int({tag, " latency"}, cyc - acc_cyc[got], w);
          check32({tag, " rdata"}, v.rsp_rdata, strm[got].exp_rdata);
          check32({tag, " err"}, {31'd0, v.rsp_err}, {31'd0, strm[got].exp_err});
        end else begin
          check_int({tag, " response without request"}, got, sent);
        end
        got++;
      end
    end
    v.req_valid = 1'b0;
    check_int({tag, " accepted"}, sent, strm.size());
    check_int({tag, " responded"}, got, strm.size());
  endtask

  initial begin
    int n;
    int seen;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = 3'd0;
    bus1.req_addr = 12'd0; bus1.req_wdata = 32'd0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = 3'd0;
    bus0.req_addr = 12'd0; bus0.req_wdata = 32'd0;

    // store/load table: {we, funct3, addr, wdata, expected rdata, expected err}
    tbl.push_back(mk(1'b1, 3'b010, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, 3'b010, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(1'b1, 3'b000, 12'h011, 32'h000000AA, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, 3'b010, 12'h010, 32'h0,        32'hDEADAAEF, 1'b0));
    tbl.push_back(mk(1'b0, 3'b000, 12'h011, 32'h0,        32'hFFFFFFAA, 1'b0));
    tbl.push_back(mk(1'b0, 3'b100, 12'h011, 32'h0,        32'h000000AA, 1'b0));
    tbl.push_back(mk(1'b0, 3'b101, 12'h012, 32'h0,        32'h0000DEAD, 1'b0));
    tbl.push_back(mk(1'b1, 3'b010, 12'h012, 32'h11111111, 32'h0, 1'b1));
    tbl.push_back(mk(1'b0, 3'b001, 12'h013, 32'h0,        32'h0, 1'b1));
    tbl.push_back(mk(1'b0, 3'b010, 12'h010, 32'h0,        32'hDEADAAEF, 1'b0));
    tbl.push_back(mk(1'b0, 3'b011, 12'h010, 32'h0,        32'h0, 1'b1));
    tbl.push_back(mk(1'b1, 3'b100, 12'h010, 32'h22222222, 32'h0, 1'b1));
    tbl.push_back(mk(1'b1, 3'b101, 12'h010, 32'h33333333, 32'h0, 1'b1));
    tbl.push_back(mk(1'b0, 3'b110, 12'h010, 32'h0,        32'h0, 1'b1));
    tbl.push_back(mk(1'b0, 3'b111, 12'h010, 32'h0,        32'h0, 1'b1));
    tbl.push_back(mk(1'b1, 3'b001, 12'h011, 32'h44444444, 32'h0, 1'b1));
    tbl.push_back(mk(1'b0, 3'b010, 12'h010, 32'h0,        32'hDEADAAEF, 1'b0));
    tbl.push_back(mk(1'b1, 3'b010, 12'h014, 32'h80007F01, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, 3'b000, 12'h014, 32'h0,        32'h00000001, 1'b0));
    tbl.push_back(mk(1'b0, 3'b000, 12'h015, 32'h0,        32'h0000007F, 1'b0));
    tbl.push_back(mk(1'b0, 3'b001, 12'h016, 32'h0,        32'hFFFF8000, 1'b0));
    tbl.push_back(mk(1'b0, 3'b101, 12'h016, 32'h0,        32'h00008000, 1'b0));
    tbl.push_back(mk(1'b1, 3'b001, 12'h016, 32'hFFFF1234, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 3'b000, 12'h017, 32'hFFFFFF55, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, 3'b010, 12'h014, 32'h0,        32'h55347F01, 1'b0));
    tbl.push_back(mk(1'b0, 3'b101, 12'h015, 32'h0,        32'h0, 1'b1));
    tbl.push_back(mk(1'b1, 3'b010, 12'hFFC, 32'h0BADF00D, 32'h0, 1'b0));
    tbl.push_back(mk(1'b0, 3'b010, 12'hFFC, 32'h0,        32'h0BADF00D, 1'b0));

    strm.push_back(mk(1'b1, 3'b010, 12'h040, 32'hA5A51234, 32'h0, 1'b0));
    strm.push_back(mk(1'b0, 3'b010, 12'h040, 32'h0,        32'hA5A51234, 1'b0));
    strm.push_back(mk(1'b1, 3'b000, 12'h041, 32'h00000077, 32'h0, 1'b0));
    strm.push_back(mk(1'b0, 3'b010, 12'h040, 32'h0,        32'hA5A57734, 1'b0));
    strm.push_back(mk(1'b0, 3'b001, 12'h042, 32'h0,        32'hFFFFA5A5, 1'b0));
    strm.push_back(mk(1'b1, 3'b010, 12'h041, 32'h0,        32'h0, 1'b1));
    strm.push_back(mk(1'b0, 3'b100, 12'h043, 32'h0,        32'h000000A5, 1'b0));

    // reset state
    #1 rst = 1'b0;
    #1;
    check_int("reset rsp_valid", int'(bus1.rsp_valid), 0);
    check32("reset rsp_rdata", bus1.rsp_rdata, 32'h0);
    check_int("reset rsp_err", int'(bus1.rsp_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_int("ready after reset", int'(bus1.req_ready), 1);
    check_int("ready after reset w0", int'(bus0.req_ready), 1);

    for (int i = 0; i < tbl.size(); i++) begin
      do_req(bus1, 1, tbl[i], $sformatf("vec%0d", i));
    end

    stream(bus1, 1, "stream w1");
    stream(bus0, 0, "stream w0");

    // reset during WAIT abandons the store
    do_req(bus1, 1, mk(1'b1, 3'b010, 12'h020, 32'hCAFEF00D, 32'h0, 1'b0), "prior store");
    do_req(bus1, 1, mk(1'b0, 3'b010, 12'h010, 32'h0, 32'hDEADAAEF, 1'b0), "pre-reset load");
    @(negedge clk);
    n = 0;
    while (!bus1.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus1.req_valid = 1'b1;
    drive(bus1, mk(1'b1, 3'b010, 12'h020, 32'h12345678, 32'h0, 1'b0));
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    check_int("in WAIT ready", int'(bus1.req_ready), 0);
    #2 rst = 1'b0;
    #1;
    check_int("abort rsp_valid", int'(bus1.rsp_valid), 0);
    check32("abort rsp_rdata", bus1.rsp_rdata, 32'h0);
    check_int("abort ready", int'(bus1.req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (bus1.rsp_valid) seen++;
    end
    check_int("no response after abort", seen, 0);
    check_int("ready after abort", int'(bus1.req_ready), 1);
    do_req(bus1, 1, mk(1'b0, 3'b010, 12'h020, 32'h0, 32'hCAFEF00D, 1'b0), "abort kept old");
    do_req(bus1, 1, mk(1'b0, 3'b010, 12'h010, 32'h0, 32'hDEADAAEF, 1'b0), "mem kept over reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
